// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, opcode constants, instruction field positions and FSM/branch enums.
// No ports; imported by seq_decode and alu_op_sequencer.
package alu_pkg;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_COMP  = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SHLLV = 4'b0100;
    localparam logic [3:0] ALU_SHRLV = 4'b0101;
    localparam logic [3:0] ALU_SHRAV = 4'b0110;
    localparam logic [3:0] ALU_SHLL  = 4'b0111;
    localparam logic [3:0] ALU_SHRL  = 4'b1000;
    localparam logic [3:0] ALU_SHRA  = 4'b1001;
    localparam logic [3:0] ALU_SFLAG = 4'b1010;
    localparam logic [3:0] ALU_ZFLAG = 4'b1011;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    localparam logic [5:0] OPC_ALU = 6'b000000;
    localparam logic [5:0] OPC_SHF = 6'b000001;
    localparam logic [5:0] OPC_IMM = 6'b000010;
    localparam logic [5:0] OPC_BRF = 6'b000011;
    localparam logic [5:0] OPC_BRC = 6'b000100;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int SH_LSB  = 10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_EXF, S_EXT, S_WB} state_t;
    typedef enum logic [2:0] {BR_LTZ, BR_Z, BR_NZ, BR_CY, BR_NCY} br_kind_t;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode/func decode into ALU op and control flags.
// Ports: opcode_i/func_i in; alu_op_o, use_imm_o, is_branch_o, br_kind_o, writes_rf_o, is_illegal_o out.
module seq_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [3:0] func_i,
    output logic [3:0] alu_op_o,
    output logic       use_imm_o,
    output logic       is_branch_o,
    output br_kind_t   br_kind_o,
    output logic       writes_rf_o,
    output logic       is_illegal_o
);
    always_comb begin
        alu_op_o     = ALU_NOP;
        use_imm_o    = 1'b0;
        is_branch_o  = 1'b0;
        br_kind_o    = BR_LTZ;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OPC_ALU: case (func_i)
                4'd0:    alu_op_o = ALU_ADD;
                4'd1:    alu_op_o = ALU_COMP;
                4'd2:    alu_op_o = ALU_AND;
                4'd3:    alu_op_o = ALU_XOR;
                default: is_illegal_o = 1'b1;
            endcase
            OPC_SHF: case (func_i)
                4'd0:    alu_op_o = ALU_SHLL;
                4'd1:    alu_op_o = ALU_SHRL;
                4'd2:    alu_op_o = ALU_SHLLV;
                4'd3:    alu_op_o = ALU_SHRLV;
                4'd4:    alu_op_o = ALU_SHRA;
                4'd5:    alu_op_o = ALU_SHRAV;
                default: is_illegal_o = 1'b1;
            endcase
            OPC_IMM: begin
                is_illegal_o = func_i > 4'd1;
                use_imm_o    = func_i <= 4'd1;
                alu_op_o     = (func_i == 4'd0) ? ALU_ADD : (func_i == 4'd1) ? ALU_COMP : ALU_NOP;
            end
            OPC_BRF: begin
                is_illegal_o = func_i > 4'd2;
                is_branch_o  = func_i <= 4'd2;
                br_kind_o    = (func_i == 4'd0) ? BR_LTZ : (func_i == 4'd1) ? BR_Z : BR_NZ;
                alu_op_o     = (func_i == 4'd0) ? ALU_SFLAG : (func_i <= 4'd2) ? ALU_ZFLAG : ALU_NOP;
            end
            // Carry branches test the architectural flag, so the ALU stays idle.
            OPC_BRC: begin
                is_illegal_o = func_i > 4'd1;
                is_branch_o  = func_i <= 4'd1;
                br_kind_o    = (func_i == 4'd0) ? BR_CY : BR_NCY;
            end
            default: is_illegal_o = 1'b1;
        endcase
    end

    assign writes_rf_o = !is_illegal_o && !is_branch_o;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle issue controller driving the KGP-RISC ALU and owning the carry flag.
// Ports: clk/rst; instr_valid/instr_ready/instr/pc_in handshake; rf_ra1/rf_ra2/rf_rd1/rf_rd2 reads;
//        rf_we/rf_wa/rf_wd writeback; alu_op/alu_x/alu_y/alu_shamt to ALU, alu_out/carry/zero/sign back;
//        br_valid/br_taken/br_target branch result; carry_q flag; done/illegal retire pulses.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    output logic [RADDR-1:0] rf_ra1,
    output logic [RADDR-1:0] rf_ra2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_wa,
    output logic [XLEN-1:0]  rf_wd,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  alu_x,
    output logic [XLEN-1:0]  alu_y,
    output logic [5:0]       alu_shamt,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             br_valid,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic             carry_q,
    output logic             done,
    output logic             illegal
);
    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q, op1_q, op2_q, res_q;
    logic            taken_q, taken_d;
    logic [3:0]      dec_op;
    logic            dec_use_imm, dec_branch, dec_writes, dec_illegal;
    br_kind_t        dec_kind;

    seq_decode u_decode (
        .opcode_i     (instr_q[OPC_LSB +: 6]),
        .func_i       (instr_q[3:0]),
        .alu_op_o     (dec_op),
        .use_imm_o    (dec_use_imm),
        .is_branch_o  (dec_branch),
        .br_kind_o    (dec_kind),
        .writes_rf_o  (dec_writes),
        .is_illegal_o (dec_illegal)
    );

    logic [RADDR-1:0] rs, rt;
    logic [XLEN-1:0]  imm_sx;
    logic             st_rd, st_ex, st_exf, st_ext, st_wb;

    assign rs     = instr_q[RS_LSB +: RADDR];
    assign rt     = instr_q[RT_LSB +: RADDR];
    assign imm_sx = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    assign st_rd  = state_q == S_RD;
    assign st_ex  = state_q == S_EX;
    assign st_exf = state_q == S_EXF;
    assign st_ext = state_q == S_EXT;
    assign st_wb  = state_q == S_WB;

    // Illegal instructions bypass execution and retire straight from RD.
    assign state_d = (state_q == S_IDLE) ? (instr_valid ? S_RD : S_IDLE)
                   : st_rd  ? (dec_illegal ? S_WB : dec_branch ? S_EXF : S_EX)
                   : st_exf ? S_EXT
                   : st_wb  ? S_IDLE
                   : S_WB;

    assign taken_d = (dec_kind == BR_LTZ) ? alu_sign
                   : (dec_kind == BR_Z)   ? alu_zero
                   : (dec_kind == BR_NZ)  ? !alu_zero
                   : (dec_kind == BR_CY)  ? carry_q
                   : !carry_q;

    assign instr_ready = state_q == S_IDLE;
    assign rf_ra1      = st_rd ? rs : '0;
    assign rf_ra2      = st_rd ? rt : '0;
    assign rf_we       = st_wb && dec_writes;
    assign rf_wa       = rf_we ? rs : '0;
    assign rf_wd       = rf_we ? res_q : '0;
    // EXT reuses the adder for the branch target; its carry is never sampled.
    assign alu_op      = (st_ex || st_exf) ? dec_op : st_ext ? ALU_ADD : ALU_NOP;
    assign alu_x       = st_ext ? pc_q : (st_ex || st_exf) ? op1_q : '0;
    assign alu_y       = st_ext ? imm_sx : st_ex ? (dec_use_imm ? imm_sx : op2_q) : st_exf ? op2_q : '0;
    assign alu_shamt   = st_ex ? instr_q[SH_LSB +: 6] : '0;
    assign br_valid    = st_wb && dec_branch;
    assign br_taken    = br_valid && taken_q;
    assign br_target   = br_valid ? res_q : '0;
    assign done        = st_wb;
    assign illegal     = st_wb && dec_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            taken_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
                pc_q    <= pc_in;
            end
            if (st_rd) begin
                op1_q <= rf_rd1;
                op2_q <= rf_rd2;
            end
            if (st_ex || st_ext) res_q <= alu_out;
            if (st_exf) taken_q <= taken_d;
            // Only add/addi define a carry; dec_op is ADD in EX for exactly those two.
            if (st_ex && dec_op == ALU_ADD) carry_q <= alu_carry;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with register-file and ALU models around alu_op_sequencer.
module tb_alu_op_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        instr_valid = 1'b0, instr_ready;
    logic [31:0] instr = '0, pc_in = '0;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [3:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_shamt;
    logic        alu_carry, alu_zero, alu_sign;
    logic        br_valid, br_taken, carry_q, done, illegal;
    logic [31:0] br_target;

    always #5 clk = ~clk;

    alu_op_sequencer #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc_in(pc_in),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .carry_q(carry_q), .done(done), .illegal(illegal)
    );

    logic [31:0] rf [32];
    logic        set_en = 1'b0;
    logic [4:0]  set_a = '0;
    logic [31:0] set_d = '0;
    always @(posedge clk)
        if (set_en) rf[set_a] <= set_d;
        else if (rf_we) rf[rf_wa] <= rf_wd;
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            4'd0:    {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            4'd1:    alu_out = ~alu_y + 32'd1;
            4'd2:    alu_out = alu_x & alu_y;
            4'd3:    alu_out = alu_x ^ alu_y;
            4'd4:    alu_out = alu_x << alu_y[4:0];
            4'd5:    alu_out = alu_x >> alu_y[4:0];
            4'd6:    alu_out = $signed(alu_x) >>> alu_y[4:0];
            4'd7:    alu_out = alu_x << alu_shamt;
            4'd8:    alu_out = alu_x >> alu_shamt;
            4'd9:    alu_out = $signed(alu_x) >>> alu_shamt;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_op == 4'd11) ? (alu_x == 32'd0) : (alu_out == 32'd0);
        alu_sign = (alu_op == 4'd10) ? alu_x[31] : alu_out[31];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr, br, ill, taken, carry;
        logic [4:0]  wa;
        logic [31:0] wd, tgt;
        logic [3:0]  op;
        int          lat, acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rf [32];
    logic        m_carry = 1'b0;
    int          n_vec = 0, n_err = 0, stray = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [5:0] sh, input logic [3:0] f);
        return {opc, rs, rt, sh, 6'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] opc, input logic [4:0] rs, input logic [15:0] imm);
        return {opc, rs, 5'd0, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [4:0]  rs, rt;
        logic [5:0]  sh;
        logic [3:0]  f;
        logic [31:0] a, b, sx, r;
        logic [32:0] s;
        logic        ill, br, tk;
        rs = ins[25:21]; rt = ins[20:16]; sh = ins[15:10]; f = ins[3:0];
        a = m_rf[rs]; b = m_rf[rt]; sx = {{16{ins[15]}}, ins[15:0]};
        r = '0; ill = 1'b0; br = 1'b0; tk = 1'b0; e.op = 4'hF;
        case (ins[31:26])
            6'd0: case (f)
                4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; m_carry = s[32]; e.op = 4'd0; end
                4'd1: begin r = -b; e.op = 4'd1; end
                4'd2: begin r = a & b; e.op = 4'd2; end
                4'd3: begin r = a ^ b; e.op = 4'd3; end
                default: ill = 1'b1;
            endcase
            6'd1: case (f)
                4'd0: begin r = a << sh; e.op = 4'd7; end
                4'd1: begin r = a >> sh; e.op = 4'd8; end
                4'd2: begin r = a << b[4:0]; e.op = 4'd4; end
                4'd3: begin r = a >> b[4:0]; e.op = 4'd5; end
                4'd4: begin r = $signed(a) >>> sh; e.op = 4'd9; end
                4'd5: begin r = $signed(a) >>> b[4:0]; e.op = 4'd6; end
                default: ill = 1'b1;
            endcase
            6'd2: case (f)
                4'd0: begin s = {1'b0, a} + {1'b0, sx}; r = s[31:0]; m_carry = s[32]; e.op = 4'd0; end
                4'd1: begin r = -sx; e.op = 4'd1; end
                default: ill = 1'b1;
            endcase
            6'd3: case (f)
                4'd0: begin br = 1'b1; tk = a[31]; e.op = 4'd10; end
                4'd1: begin br = 1'b1; tk = a == 32'd0; e.op = 4'd11; end
                4'd2: begin br = 1'b1; tk = a != 32'd0; e.op = 4'd11; end
                default: ill = 1'b1;
            endcase
            6'd4: case (f)
                4'd0: begin br = 1'b1; tk = m_carry; end
                4'd1: begin br = 1'b1; tk = !m_carry; end
                default: ill = 1'b1;
            endcase
            default: ill = 1'b1;
        endcase
        e.ill = ill; e.br = br; e.wr = !ill && !br; e.taken = tk;
        e.tgt = pc + sx; e.wa = rs; e.wd = r;
        e.lat = ill ? 0 : br ? 4 : 3;
        if (e.wr) m_rf[rs] = r;
        e.carry = m_carry;
        e.acc = 0;
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((rf_we || br_valid || illegal) && !done) stray++;
            if (sb.size() > 0 && cyc == sb[0].acc + 2) chk("ex_alu_op", 32'(alu_op), 32'(sb[0].op));
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rf_we", 32'(rf_we), 32'(e.wr));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("br_valid", 32'(br_valid), 32'(e.br));
                    chk("carry_q", 32'(carry_q), 32'(e.carry));
                    if (e.wr) begin
                        chk("rf_wa", 32'(rf_wa), 32'(e.wa));
                        chk("rf_wd", rf_wd, e.wd);
                    end
                    if (e.br) begin
                        chk("br_taken", 32'(br_taken), 32'(e.taken));
                        chk("br_target", br_target, e.tgt);
                    end
                    if (e.lat > 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic setreg(input int a, input logic [31:0] d);
        @(negedge clk);
        set_en = 1'b1; set_a = a[4:0]; set_d = d; m_rf[a] = d;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e = model(ins, pc);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 30) begin @(negedge clk); n++; end
        if (sb.size() > 0) begin chk("done_timeout", 32'd0, 32'd1); sb.delete(); end
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        instr = ins; pc_in = pc; instr_valid = 1'b1;
        wait_ready();
        accept(ins, pc);
        @(negedge clk);
        instr_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_a, acc_b;
        for (int i = 0; i < 32; i++) setreg(i, 32'd0);
        setreg(1, 32'hFFFFFFFF); setreg(2, 32'h00000001);
        setreg(3, 32'hF0F0F0F0); setreg(4, 32'hFFFF0000);
        setreg(5, 32'h80000000);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'hF);
        chk("rst_carry", 32'(carry_q), 32'd0);
        chk("rst_alu_x", alu_x, 32'd0);
        chk("rst_rf_wa", 32'(rf_wa), 32'd0);

        issue(r_ins(6'd0, 5'd1, 5'd2, 6'd0, 4'd0), 32'd0);
        issue(r_ins(6'd0, 5'd3, 5'd4, 6'd0, 4'd3), 32'd0);
        issue(r_ins(6'd1, 5'd5, 5'd0, 6'd4, 4'd4), 32'd0);
        issue(i_ins(6'd4, 5'd0, 16'h0010), 32'h00000100);
        issue(i_ins(6'd4, 5'd0, 16'h0021), 32'h00000100);
        issue(i_ins(6'd4, 5'd0, 16'h0020), 32'hFFFFFFF0);
        setreg(6, 32'd0);
        issue(i_ins(6'd3, 5'd6, 16'hFFF1), 32'h00000020);
        setreg(6, 32'd5);
        issue(i_ins(6'd3, 5'd6, 16'hFFF1), 32'h00000020);
        issue(i_ins(6'd3, 5'd6, 16'hFFF2), 32'h00000020);
        setreg(6, 32'h80000001);
        issue(i_ins(6'd3, 5'd6, 16'h0040), 32'h00001000);
        issue({6'h3F, 26'd0}, 32'd0);
        issue(r_ins(6'd0, 5'd1, 5'd2, 6'd0, 4'd7), 32'd0);
        setreg(7, 32'h7FFFFFFF);
        issue(i_ins(6'd2, 5'd7, 16'h0010), 32'd0);
        setreg(8, 32'hFFFFFFF0);
        issue(i_ins(6'd2, 5'd8, 16'h0010), 32'd0);
        setreg(9, 32'd5);
        issue(i_ins(6'd2, 5'd9, 16'hFFF0), 32'd0);

        @(negedge clk);
        instr = r_ins(6'd0, 5'd3, 5'd4, 6'd0, 4'd3); instr_valid = 1'b1;
        wait_ready();
        acc_a = cyc;
        accept(instr, 32'd0);
        @(negedge clk);
        instr = r_ins(6'd1, 5'd5, 5'd0, 6'd1, 4'd0);
        chk("busy_ready", 32'(instr_ready), 32'd0);
        wait_ready();
        acc_b = cyc;
        chk("busy_accept_gap", 32'(acc_b - acc_a), 32'd4);
        accept(instr, 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        drain();

        setreg(1, 32'hFFFFFFFF);
        issue(r_ins(6'd0, 5'd1, 5'd2, 6'd0, 4'd0), 32'd0);
        setreg(1, 32'hFFFFFFFF);
        @(negedge clk);
        instr = r_ins(6'd0, 5'd1, 5'd2, 6'd0, 4'd0); instr_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_ex_alu_op", 32'(alu_op), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(instr_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_carry", 32'(carry_q), 32'd0);
        m_carry = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", rf[1], 32'hFFFFFFFF);
        issue(r_ins(6'd0, 5'd3, 5'd4, 6'd0, 4'd2), 32'd0);

        chk("stray_pulses", 32'(stray), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle issue controller that drives the KGP-RISC ALU. It accepts one instruction per handshake, reads operands from the register file, and sequences one or two ALU operations. It then writes the result back (two-address form: rs <- rs op rt) or resolves a branch, and it owns the architectural carry flag.

Parameters:
XLEN, 32, datapath width
RADDR, 5, register address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE
instr  in  32  opcode[31:26] rs[25:21] rt[20:16] shamt[15:10] func[3:0] imm[15:0]
pc_in  in  XLEN  PC of offered instruction
rf_ra1 / rf_ra2  out  RADDR  read addresses (rs, rt)
rf_rd1 / rf_rd2  in  XLEN  read data, combinational from registered addresses
rf_we  out  1  write-enable pulse
rf_wa  out  RADDR  write address
rf_wd  out  XLEN  write data
alu_op  out  4  ALU operation
alu_x / alu_y  out  XLEN  ALU operands
alu_shamt  out  6  shift amount
alu_out  in  XLEN  ALU result
alu_carry / alu_zero / alu_sign  in  1  ALU flags
br_valid  out  1  branch resolved pulse
br_taken  out  1  branch decision
br_target  out  XLEN  pc_in + sign-extended imm
carry_q  out  1  architectural carry flag
done  out  1  instruction retired pulse
illegal  out  1  pulse with done on undefined opcode/func

Behaviour:
- Reset: FSM to IDLE; carry_q=0; all pulses and rf_we=0; alu_op=4'b1111 (ALU default: out=0); rf/alu address and data outputs 0. Reset mid-instruction abandons it; no write, no done.
- States: IDLE -> RD -> EX -> WB -> IDLE. The branch path is IDLE -> RD -> EXF -> EXT -> WB.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and pc_in, go to RD.
- RD: drive rf_ra1=rs, rf_ra2=rt. Sample rf_rd1/rf_rd2 into op registers at the end of the cycle.
- EX: drive alu_op/x/y/shamt from the decode. Capture alu_out into res_q. If op is add or addi, carry_q<=alu_carry; otherwise carry_q holds.
- WB: rf_we=1, rf_wa=rs, rf_wd=res_q, done=1.
- Latency: accept at cycle 0, write/done at cycle 3 (branch: cycle 4). Throughput: 1 per 4 (5) cycles.
- Decode and ALU op codes:
  - opcode 000000, func 0..3 = add 0000, comp 0001, and 0010, xor 0011.
  - opcode 000001, func 0..5 = shll 0111, shrl 1000, shllv 0100, shrlv 0101, shra 1001, shrav 0110.
  - opcode 000010, func 0 = addi (y=sext(imm), op 0000); func 1 = compi (y=sext(imm), op 0001).
  - opcode 000011, func 0..2 = bltz (op 1010 on rs), bz (op 1011), bnz (op 1011).
  - opcode 000100, func 0..1 = bcy / bncy: no flag op, EXF uses carry_q.
- Branch path:
  - EXF latches the decision: bltz=alu_sign, bz=alu_zero, bnz=~alu_zero, bcy=carry_q, bncy=~carry_q.
  - EXT drives op 0000 with x=pc_q and y=sext(imm). alu_out becomes br_target. This is 32-bit wrap-around; alu_carry is ignored and carry_q is unchanged.
  - WB: br_valid=1, br_taken, done=1; rf_we=0.
- Illegal opcode/func: skip EX; WB with rf_we=0, done=1, illegal=1, carry_q unchanged.
- Sample alu_carry only in EX of add/addi, because the ALU does not define carry for other ops.
- Outside EX/EXF/EXT, alu_op=4'b1111.
- Writes to r0 are not special-cased; the register file owns that.

Decomposition:
- Package alu_pkg: ALU op localparams (ADD..ZFLAG, NOP=4'b1111), opcode/func constants, instruction field index constants, FSM state enum.
- One sub-module: seq_decode (combinational instr -> alu_op, imm-select, is_branch, br_kind, writes_rf, is_illegal).
- The FSM and registers stay in alu_op_sequencer.

Test Plan:
- add r1,r2 with rf r1=0xFFFFFFFF, r2=0x00000001 -> cycle 3: rf_we, wa=1, wd=0x00000000, carry_q=1, done.
- xor r3,r4 with r3=0xF0F0F0F0, r4=0xFFFF0000 (after the add above) -> wd=0x0F0FF0F0, carry_q stays 1.
- shra r5 shamt=4 with r5=0x80000000 -> alu_op=1001, wd=0xF8000000. Then bcy pc=0x100 imm=0x0010 -> br_taken=1, br_target=0x110, rf_we=0.
- bz r6 imm=0xFFFC pc=0x20: r6=0 -> br_taken=1, target=0x1C; r6=5 -> br_taken=0. bltz with r6=0x80000001 -> taken.
- opcode 111111 -> done=1, illegal=1, no rf_we, carry_q unchanged. Also: instr_valid held during busy is not accepted until instr_ready returns.
- rst asserted in EX of add with carry overflow -> no rf_we/done, carry_q=0, instr_ready=1 the next cycle.
